sh4a_fetch: RTL

//  Instruction fetch front end: the producer side of the decoder's insn input.
//  It generates word-aligned 32-bit memory reads and splits each returned word into two 16-bit SH-4 instructions.
//  It buffers them in a small halfword FIFO and presents them with their PC over a valid/ready handshake.

---
 rtl/sh4a_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sh4a_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sh4a_fetch
// Brief    : SH-4 fetch front end: word reads split into a halfword {pc,insn} FIFO
// Revision : 1.0
// ============================================================================
module sh4a_fetch #(
   parameter logic [31:0] RESET_PC = 32'hA000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        insn_valid,
   output logic [15:0] insn,
   output logic [31:0] insn_pc,
   input  logic        insn_ready
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [31:0]        r_fetch_pc, w_fetch_pc_nxt;
   logic [CNT_W-1:0]   r_count, w_free, w_push_n;
   logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr, w_hi_ptr;
   logic [15:0]        r_fifo_insn [DEPTH];
   logic [31:0]        r_fifo_pc   [DEPTH];
   logic               w_push_lo, w_push_hi, w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_free        = c_depth - r_count;
   assign w_pop         = insn_valid && insn_ready;
   assign w_push_n      = CNT_W'(w_push_lo) + CNT_W'(w_push_hi);
   assign w_hi_ptr      = w_push_lo ? ptr_inc(r_wr_ptr) : r_wr_ptr;

   assign mem_req_valid = (r_state == ST_REQ);
   assign mem_req_addr  = {r_fetch_pc[31:2], 2'b00};
   assign insn_valid    = (r_count != '0);
   assign insn          = r_fifo_insn[r_rd_ptr];
   assign insn_pc       = r_fifo_pc[r_rd_ptr];

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_push_lo      = 1'b0;
      w_push_hi      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!redirect_valid && (w_free >= CNT_W'(2)))
               w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid)
               w_state_nxt = mem_req_ready ? ST_DRAIN : ST_IDLE;
            else if (mem_req_ready)
               w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               w_state_nxt = mem_rsp_valid ? ST_IDLE : ST_DRAIN;
            end else if (mem_rsp_valid) begin
               // an odd-halfword start skips the low half of the word
               w_push_lo      = !r_fetch_pc[1];
               w_push_hi      = 1'b1;
               w_fetch_pc_nxt = {r_fetch_pc[31:2] + 30'd1, 2'b00};
               w_state_nxt    = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_rsp_valid)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (redirect_valid)
         w_fetch_pc_nxt = redirect_pc & ~32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC & ~32'd1;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            r_count <= r_count + w_push_n - CNT_W'(w_pop);
            if (w_pop)
               r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push_hi)
               r_wr_ptr <= ptr_inc(w_hi_ptr);
         end
      end
   end

   // fetch_pc bit0 is zero by construction and carries into the stored PC
   always_ff @(posedge clk) begin
      if (w_push_lo) begin
         r_fifo_insn[r_wr_ptr] <= mem_rsp_data[15:0];
         r_fifo_pc[r_wr_ptr]   <= {r_fetch_pc[31:2], 1'b0, r_fetch_pc[0]};
      end
      if (w_push_hi) begin
         r_fifo_insn[w_hi_ptr] <= mem_rsp_data[31:16];
         r_fifo_pc[w_hi_ptr]   <= {r_fetch_pc[31:2], 1'b1, r_fetch_pc[0]};
      end
   end

   a_count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
      r_count <= c_depth);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, r_count} + {1'b0, w_push_n}) <= ({1'b0, c_depth} + {{CNT_W{1'b0}}, w_pop}));
   a_addr_align: assert property (@(posedge clk) disable iff (!rst_n)
      mem_req_valid |-> (mem_req_addr[1:0] == 2'b00));
   a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (mem_req_valid && !mem_req_ready && !redirect_valid) |=> (mem_req_valid && $stable(mem_req_addr)));
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      !(mem_rsp_valid && ((r_state == ST_IDLE) || (r_state == ST_REQ))));

endmodule
`default_nettype wire
